mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
//==============================================================================
// Module : mem_arbiter_if
// Brief  : Fetch / MEM-stage / shared-memory bundle for mem_arbiter.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        me_req;
    logic        me_we;
    logic [31:0] me_addr;
    logic [31:0] me_wdata;
    logic        me_ack;
    logic [31:0] me_rdata;
    logic        err;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport slave (
        input  if_req, if_addr, me_req, me_we, me_addr, me_wdata, mem_rdata, mem_ready,
        output if_ack, if_rdata, me_ack, me_rdata, err, stall,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, me_req, me_we, me_addr, me_wdata, mem_rdata, mem_ready,
        input  if_ack, if_rdata, me_ack, me_rdata, err, stall,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
//==============================================================================
// Module : mem_arbiter
// Brief  : Shares one memory port between fetch and MEM stage, ME priority
//          with anti-starvation for fetch and a BUSY timeout.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 15
) (
    input  wire logic       clock,
    input  wire logic       reset_0,
    mem_arbiter_if.slave    bus
);

    localparam int c_SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int c_WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_LIMIT);
    localparam logic [c_WW-1:0] c_WAIT_LAST  = c_WW'(TIMEOUT - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_BUSY_IF = 2'd1;
    localparam logic [1:0] c_ST_BUSY_ME = 2'd2;
    localparam logic [1:0] c_ST_DONE    = 2'd3;

    logic [1:0]      r_state;
    logic [c_SW-1:0] r_starve_cnt;
    logic [c_WW-1:0] r_wait_cnt;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [31:0]     r_mem_addr;
    logic [31:0]     r_mem_wdata;
    logic            r_if_ack;
    logic            r_me_ack;
    logic            r_err;
    logic [31:0]     r_if_rdata;
    logic [31:0]     r_me_rdata;

    logic            w_pick_me;
    logic            w_timeout;

    // ME wins unless a waiting fetch has already been passed over STARVE_LIMIT times
    assign w_pick_me = bus.me_req & ~(bus.if_req & (r_starve_cnt == c_STARVE_MAX));
    assign w_timeout = (r_wait_cnt == c_WAIT_LAST);

    always_ff @(posedge clock) begin
        if (reset_0) begin
            r_state      <= c_ST_IDLE;
            r_starve_cnt <= '0;
            r_wait_cnt   <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 32'd0;
            r_if_ack     <= 1'b0;
            r_me_ack     <= 1'b0;
            r_err        <= 1'b0;
            r_if_rdata   <= 32'd0;
            r_me_rdata   <= 32'd0;
        end else begin
            r_if_ack <= 1'b0;
            r_me_ack <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pick_me) begin
                        r_state     <= c_ST_BUSY_ME;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= bus.me_we;
                        r_mem_addr  <= bus.me_addr;
                        r_mem_wdata <= bus.me_wdata;
                        r_wait_cnt  <= '0;
                        if (bus.if_req && (r_starve_cnt != c_STARVE_MAX))
                            r_starve_cnt <= r_starve_cnt + 1'b1;
                    end else if (bus.if_req) begin
                        r_state      <= c_ST_BUSY_IF;
                        r_mem_req    <= 1'b1;
                        r_mem_we     <= 1'b0;
                        r_mem_addr   <= bus.if_addr;
                        r_mem_wdata  <= 32'd0;
                        r_wait_cnt   <= '0;
                        r_starve_cnt <= '0;
                    end
                end
                c_ST_BUSY_IF, c_ST_BUSY_ME: begin
                    if (bus.mem_ready) begin
                        r_state   <= c_ST_DONE;
                        r_mem_req <= 1'b0;
                        if (r_state == c_ST_BUSY_IF) begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= bus.mem_rdata;
                        end else begin
                            r_me_ack   <= 1'b1;
                            r_me_rdata <= bus.mem_rdata;
                        end
                    end else if (w_timeout) begin
                        // Forced completion: requester sees an ack with err and zero data
                        r_state   <= c_ST_DONE;
                        r_mem_req <= 1'b0;
                        r_err     <= 1'b1;
                        if (r_state == c_ST_BUSY_IF) begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= 32'd0;
                        end else begin
                            r_me_ack   <= 1'b1;
                            r_me_rdata <= 32'd0;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.if_ack    = r_if_ack;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.me_ack    = r_me_ack;
    assign bus.me_rdata  = r_me_rdata;
    assign bus.err       = r_err;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.stall     = (bus.if_req & ~r_if_ack) | (bus.me_req & ~r_me_ack);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//==============================================================================
// Module : tb_mem_arbiter
// Brief  : Directed self-checking bench for mem_arbiter.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic clock;
    logic reset_0;
    int   n_checks;
    int   n_errors;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(15)) dut (
        .clock   (clock),
        .reset_0 (reset_0),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Advance to just after the next rising edge; checks and input changes happen here.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_0        = 1'b1;
        bus.if_req     = 1'b0;
        bus.if_addr    = 32'd0;
        bus.me_req     = 1'b0;
        bus.me_we      = 1'b0;
        bus.me_addr    = 32'd0;
        bus.me_wdata   = 32'd0;
        bus.mem_rdata  = 32'd0;
        bus.mem_ready  = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({bus.mem_req, bus.mem_we, bus.if_ack, bus.me_ack, bus.err, bus.stall} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b required 000000",
                     {bus.mem_req, bus.mem_we, bus.if_ack, bus.me_ack, bus.err, bus.stall});
        end
        n_checks++;
        if ({bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.me_rdata} !== 128'd0) begin
            n_errors++;
            $display("FAIL reset_data: got %h %h %h %h required all zero",
                     bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.me_rdata);
        end
        n_checks++;
        if (dut.r_starve_cnt !== 3'd0) begin
            n_errors++;
            $display("FAIL reset_starve: got %0d required 0", dut.r_starve_cnt);
        end
        reset_0 = 1'b0;
    endtask

    task automatic test_single_fetch();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_checks++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_we !== 1'b0 ||
                bus.if_ack !== 1'b0 || bus.stall !== 1'b1) begin
                n_errors++;
                $display("FAIL fetch_busy c%0d: got req=%b addr=%h we=%b ack=%b stall=%b required 1 00000100 0 0 1",
                         c, bus.mem_req, bus.mem_addr, bus.mem_we, bus.if_ack, bus.stall);
            end
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hDEADBEEF;
        tick();
        bus.mem_ready = 1'b0;
        n_checks++;
        if (bus.if_ack !== 1'b1 || bus.if_rdata !== 32'hDEADBEEF || bus.stall !== 1'b0 ||
            bus.mem_req !== 1'b0 || bus.err !== 1'b0) begin
            n_errors++;
            $display("FAIL fetch_ack: got ack=%b rdata=%h stall=%b req=%b err=%b required 1 deadbeef 0 0 0",
                     bus.if_ack, bus.if_rdata, bus.stall, bus.mem_req, bus.err);
        end
        bus.if_req = 1'b0;
        tick();
        n_checks++;
        if (bus.if_ack !== 1'b0 || bus.if_rdata !== 32'hDEADBEEF || bus.mem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL fetch_after: got ack=%b rdata=%h req=%b required 0 deadbeef 0",
                     bus.if_ack, bus.if_rdata, bus.mem_req);
        end
    endtask

    task automatic test_priority();
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h200;
        bus.me_req   = 1'b1;
        bus.me_we    = 1'b1;
        bus.me_addr  = 32'h40;
        bus.me_wdata = 32'h55;
        tick();
        n_checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h40 ||
            bus.mem_wdata !== 32'h55 || bus.stall !== 1'b1) begin
            n_errors++;
            $display("FAIL prio_me_grant: got req=%b we=%b addr=%h wdata=%h stall=%b required 1 1 40 55 1",
                     bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.stall);
        end
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        n_checks++;
        if (bus.me_ack !== 1'b1 || bus.if_ack !== 1'b0 || bus.err !== 1'b0 ||
            bus.mem_req !== 1'b0 || bus.stall !== 1'b1) begin
            n_errors++;
            $display("FAIL prio_me_ack: got me_ack=%b if_ack=%b err=%b req=%b stall=%b required 1 0 0 0 1",
                     bus.me_ack, bus.if_ack, bus.err, bus.mem_req, bus.stall);
        end
        bus.me_req = 1'b0;
        tick();
        n_checks++;
        if (bus.mem_req !== 1'b0 || bus.me_ack !== 1'b0 || bus.stall !== 1'b1) begin
            n_errors++;
            $display("FAIL prio_idle: got req=%b me_ack=%b stall=%b required 0 0 1",
                     bus.mem_req, bus.me_ack, bus.stall);
        end
        tick();
        n_checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h200 ||
            bus.mem_wdata !== 32'd0) begin
            n_errors++;
            $display("FAIL prio_if_grant: got req=%b we=%b addr=%h wdata=%h required 1 0 200 0",
                     bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hCAFE0001;
        tick();
        bus.mem_ready = 1'b0;
        n_checks++;
        if (bus.if_ack !== 1'b1 || bus.if_rdata !== 32'hCAFE0001 || bus.stall !== 1'b0) begin
            n_errors++;
            $display("FAIL prio_if_ack: got ack=%b rdata=%h stall=%b required 1 cafe0001 0",
                     bus.if_ack, bus.if_rdata, bus.stall);
        end
        bus.if_req = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        int me_cnt;
        bit got_if;
        me_cnt        = 0;
        got_if        = 1'b0;
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h300;
        bus.me_req    = 1'b1;
        bus.me_we     = 1'b0;
        bus.me_addr   = 32'h80;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hCAFE0001;
        for (int i = 0; i < 40 && !got_if; i++) begin
            tick();
            if (bus.me_ack === 1'b1) me_cnt++;
            if (bus.if_ack === 1'b1) begin
                got_if = 1'b1;
                n_checks++;
                if (me_cnt !== 4) begin
                    n_errors++;
                    $display("FAIL starve_me_grants: got %0d required 4", me_cnt);
                end
                n_checks++;
                if (dut.r_starve_cnt !== 3'd0) begin
                    n_errors++;
                    $display("FAIL starve_cnt_clear: got %0d required 0", dut.r_starve_cnt);
                end
            end
        end
        n_checks++;
        if (!got_if) begin
            n_errors++;
            $display("FAIL starve_if_served: got no if_ack in 40 cycles required one");
        end
        bus.if_req    = 1'b0;
        bus.me_req    = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        bus.me_req  = 1'b1;
        bus.me_we   = 1'b0;
        bus.me_addr = 32'h44;
        for (int c = 1; c <= 15; c++) begin
            tick();
            n_checks++;
            if (bus.me_ack !== 1'b0 || bus.mem_req !== 1'b1 || bus.err !== 1'b0) begin
                n_errors++;
                $display("FAIL timeout_busy c%0d: got ack=%b req=%b err=%b required 0 1 0",
                         c, bus.me_ack, bus.mem_req, bus.err);
            end
        end
        tick();
        n_checks++;
        if (bus.me_ack !== 1'b1 || bus.err !== 1'b1 || bus.me_rdata !== 32'd0 || bus.mem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_ack: got ack=%b err=%b rdata=%h req=%b required 1 1 0 0",
                     bus.me_ack, bus.err, bus.me_rdata, bus.mem_req);
        end
        bus.me_req    = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h12345678;
        tick();
        bus.mem_ready = 1'b0;
        tick();
        n_checks++;
        if (bus.me_ack !== 1'b0 || bus.err !== 1'b0 || bus.me_rdata !== 32'd0 || bus.mem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_late_ready: got ack=%b err=%b rdata=%h req=%b required 0 0 0 0",
                     bus.me_ack, bus.err, bus.me_rdata, bus.mem_req);
        end
    endtask

    task automatic test_reset_mid_access();
        bus.me_req   = 1'b1;
        bus.me_we    = 1'b1;
        bus.me_addr  = 32'h88;
        bus.me_wdata = 32'h77;
        tick();
        n_checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h88) begin
            n_errors++;
            $display("FAIL rst_mid_grant: got req=%b addr=%h required 1 88", bus.mem_req, bus.mem_addr);
        end
        reset_0 = 1'b1;
        tick();
        n_checks++;
        if (bus.mem_req !== 1'b0 || bus.me_ack !== 1'b0 || bus.mem_addr !== 32'd0) begin
            n_errors++;
            $display("FAIL rst_mid_abort: got req=%b ack=%b addr=%h required 0 0 0",
                     bus.mem_req, bus.me_ack, bus.mem_addr);
        end
        reset_0       = 1'b0;
        bus.me_req    = 1'b0;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        n_checks++;
        if (bus.me_ack !== 1'b0 || bus.mem_req !== 1'b0 || bus.err !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_ready: got ack=%b req=%b err=%b required 0 0 0",
                     bus.me_ack, bus.mem_req, bus.err);
        end
        tick();
        n_checks++;
        if (bus.me_ack !== 1'b0 || bus.mem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_idle: got ack=%b req=%b required 0 0", bus.me_ack, bus.mem_req);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_single_fetch();
        test_priority();
        test_starvation();
        test_timeout();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
